// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrseq_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0__pwrseq_pkg: shared states, default sizing and counter width helper
package gf180mcu_fd_sc_mcu9t5v0__pwrseq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DEB, S_RAMP, S_ON, S_DOWN} state_t;
  localparam int DEF_DEBOUNCE  = 16;
  localparam int DEF_STAGGER   = 8;
  localparam int DEF_N_DOMAINS = 4;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrseq_sync2.sv
// gf180mcu_fd_sc_mcu9t5v0__pwrseq_sync2: two-flop level synchroniser with sync active-low reset
module gf180mcu_fd_sc_mcu9t5v0__pwrseq_sync2 (
  input  logic clk,
  input  logic rn,
  input  logic d,
  output logic q
);
  logic [1:0] s_q, s_d;
  // shift the raw level one stage per clock
  always_comb s_d = {s_q[0], d};
  // resynchronising stages, cleared by reset
  always_ff @(posedge clk) s_q <= rn ? s_d : 2'b00;
  assign q = s_q[1];
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrseq.sv
// gf180mcu_fd_sc_mcu9t5v0__pwrseq: debounced power-domain sequencer with staggered ramp, orderly shutdown and supply-loss collapse
module gf180mcu_fd_sc_mcu9t5v0__pwrseq
  import gf180mcu_fd_sc_mcu9t5v0__pwrseq_pkg::*;
#(
  parameter int DEBOUNCE  = DEF_DEBOUNCE,
  parameter int STAGGER   = DEF_STAGGER,
  parameter int N_DOMAINS = DEF_N_DOMAINS
) (
`ifdef USE_POWER_PINS
  inout  wire                   VDD,
  inout  wire                   VSS,
`endif
  input  logic                  CLK,
  input  logic                  RN,
  input  logic                  PG,
  input  logic                  SHDN_REQ,
  output logic [N_DOMAINS-1:0]  EN,
  output logic                  RSTN_OUT,
  output logic                  READY,
  output logic                  SHDN_ACK,
  output logic                  FAULT
);
  localparam int CW = cnt_width(DEBOUNCE, STAGGER);
  localparam int IW = $clog2(N_DOMAINS) + 1;
  localparam logic [CW-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_DOMAINS-1:0] en_q, en_d;
  logic rdy_q, rdy_d, done_q, done_d, ack_q, ack_d, fault_q, fault_d;
  logic pg_s;
  gf180mcu_fd_sc_mcu9t5v0__pwrseq_sync2 u_sync (.clk(CLK), .rn(RN), .d(PG), .q(pg_s));
  // next state: debounce, staggered ramp up/down, supply loss overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    idx_d   = idx_q;
    en_d    = en_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    ack_d   = done_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (pg_s && !SHDN_REQ) begin
        state_d = S_DEB;
        cnt_d   = '0;
      end
      S_DEB: if (!pg_s) state_d = S_IDLE;
      else if (cnt_q == CW'(DEBOUNCE - 2)) begin
        state_d = S_RAMP;
        cnt_d   = '0;
        idx_d   = '0;
        en_d    = N_DOMAINS'(1);
        fault_d = 1'b0;
      end
      S_RAMP: if (cnt_q == CW'(STAGGER - 1)) begin
        cnt_d = '0;
        if (idx_q == IW'(N_DOMAINS - 1)) begin
          state_d = S_ON;
          rdy_d   = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
          en_d  = en_q | (N_DOMAINS'(1) << (idx_q + 1'b1));
        end
      end
      S_ON: if (SHDN_REQ) begin
        state_d = S_DOWN;
        rdy_d   = 1'b0;
        cnt_d   = '0;
      end
      S_DOWN: if (cnt_q == CW'(STAGGER - 1)) begin
        cnt_d = '0;
        en_d  = en_q & ~(N_DOMAINS'(1) << idx_q);
        if (idx_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else idx_d = idx_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (!pg_s && (state_q inside {S_RAMP, S_ON, S_DOWN})) begin
      state_d = S_IDLE;
      en_d    = '0;
      rdy_d   = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b1;
    end
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
    end
  end
  assign EN       = en_q;
  assign RSTN_OUT = rdy_q;
  assign READY    = rdy_q;
  assign SHDN_ACK = ack_q;
  assign FAULT    = fault_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrseq.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__pwrseq: directed scenarios checked against a time-mark model and literal edge expectations
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrseq;
  localparam int D = 4;
  localparam int S = 2;
  localparam int N = 3;
  localparam int M_OFF = 0, M_DEB = 1, M_UP = 2, M_ON = 3, M_DOWN = 4;
  logic clk = 1'b0, RN = 1'b0, PG = 1'b0, SHDN_REQ = 1'b0;
  logic [N-1:0] EN;
  logic RSTN_OUT, READY, SHDN_ACK, FAULT;
  int total = 0, passed = 0, edge_n = 0;
  int mode = M_OFF, t_mark = 0, bits = 0, el = 0, ack_at = -1;
  logic h0 = 1'b0, h1 = 1'b0, pgs = 1'b0;
  logic m_rdy = 1'b0, m_fault = 1'b0, m_ack = 1'b0;
  logic [N-1:0] m_en;

  gf180mcu_fd_sc_mcu9t5v0__pwrseq #(.DEBOUNCE(D), .STAGGER(S), .N_DOMAINS(N)) dut (
    .CLK(clk), .RN(RN), .PG(PG), .SHDN_REQ(SHDN_REQ),
    .EN(EN), .RSTN_OUT(RSTN_OUT), .READY(READY), .SHDN_ACK(SHDN_ACK), .FAULT(FAULT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, got, exp);
  endtask

  task automatic to_edge(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  // model: how many domains should be on follows from elapsed time since the ramp/shutdown mark
  always @(posedge clk) begin
    edge_n++;
    if (!RN) begin
      h0 = 0; h1 = 0; mode = M_OFF; bits = 0; m_rdy = 0; m_fault = 0; ack_at = -1;
    end else begin
      pgs = h1; h1 = h0; h0 = PG;
      if (!pgs && mode >= M_UP) begin
        mode = M_OFF; bits = 0; m_rdy = 0; m_fault = 1;
      end else if (mode == M_OFF) begin
        if (pgs && !SHDN_REQ) begin mode = M_DEB; t_mark = edge_n; end
      end else if (mode == M_DEB) begin
        if (!pgs) mode = M_OFF;
        else if (edge_n == t_mark + D - 1) begin mode = M_UP; t_mark = edge_n; bits = 1; m_fault = 0; end
      end else if (mode == M_UP) begin
        el = edge_n - t_mark;
        bits = (el / S + 1 > N) ? N : el / S + 1;
        if (el >= N * S) begin m_rdy = 1; mode = M_ON; end
      end else if (mode == M_ON) begin
        if (SHDN_REQ) begin mode = M_DOWN; t_mark = edge_n; m_rdy = 0; end
      end else begin
        el = edge_n - t_mark;
        bits = N - el / S;
        if (bits <= 0) begin bits = 0; mode = M_OFF; ack_at = edge_n + 1; end
      end
    end
    m_ack = (edge_n == ack_at);
    m_en = N'((1 << bits) - 1);
  end

  // every cycle the registered outputs must match the model
  always @(negedge clk)
    if (edge_n > 0)
      chk("model", 8'({EN, RSTN_OUT, READY, SHDN_ACK, FAULT}), 8'({m_en, m_rdy, m_rdy, m_ack, m_fault}));

  initial begin
    to_edge(2);
    chk("rst_en", 8'(EN), 8'h0);
    chk("rst_flags", 8'({RSTN_OUT, READY, SHDN_ACK, FAULT}), 8'h0);
    RN = 1;
    to_edge(4);  PG = 1;
    to_edge(9);  chk("up_en_pre", 8'(EN), 8'h0);
    to_edge(10); chk("up_en0", 8'(EN), 8'h1);
    to_edge(11); chk("up_en0_hold", 8'(EN), 8'h1);
    to_edge(12); chk("up_en1", 8'(EN), 8'h3);
    to_edge(14); chk("up_en2", 8'(EN), 8'h7);
    to_edge(15); chk("up_ready_pre", 8'(READY), 8'h0);
    to_edge(16); chk("up_ready", 8'({RSTN_OUT, READY}), 8'h3);
    to_edge(19); chk("on_rstn", 8'(RSTN_OUT), 8'h1); SHDN_REQ = 1;
    to_edge(20); chk("dn_rstn", 8'({RSTN_OUT, READY}), 8'h0); chk("dn_en_s0", 8'(EN), 8'h7);
    to_edge(21); chk("dn_en_hold", 8'(EN), 8'h7);
    to_edge(22); chk("dn_en2", 8'(EN), 8'h3);
    to_edge(24); chk("dn_en1", 8'(EN), 8'h1);
    to_edge(26); chk("dn_en0", 8'(EN), 8'h0); chk("dn_ack_pre", 8'(SHDN_ACK), 8'h0);
    to_edge(27); chk("dn_ack", 8'(SHDN_ACK), 8'h1);
    to_edge(28); chk("dn_ack_post", 8'(SHDN_ACK), 8'h0);
    to_edge(32); chk("no_restart", 8'(EN), 8'h0); PG = 0; SHDN_REQ = 0;
    to_edge(40); PG = 1;
    to_edge(43); PG = 0;
    to_edge(46); chk("glitch_en", 8'(EN), 8'h0);
    to_edge(50); chk("glitch_flags", 8'({EN, FAULT}), 8'h0); PG = 1;
    to_edge(56); chk("r2_en0", 8'(EN), 8'h1);
    to_edge(57); PG = 0;
    to_edge(58); chk("r2_en1", 8'(EN), 8'h3);
    to_edge(59); chk("flt_pre", 8'({EN, FAULT}), 8'h6);
    to_edge(60); chk("flt_en", 8'(EN), 8'h0); chk("flt_set", 8'({RSTN_OUT, FAULT}), 8'h1);
    to_edge(62); PG = 1;
    to_edge(67); chk("flt_sticky", 8'({EN, FAULT}), 8'h1);
    to_edge(68); chk("flt_clear", 8'({EN, FAULT}), 8'h2);
    to_edge(72); chk("r3_en", 8'(EN), 8'h7);
    to_edge(74); chk("r3_ready", 8'(READY), 8'h1);
    to_edge(75); PG = 0;
    to_edge(77); chk("sim_pre", 8'(READY), 8'h1); SHDN_REQ = 1;
    to_edge(78); chk("sim_fault", 8'({EN, READY, SHDN_ACK, FAULT}), 8'h1);
    to_edge(79); chk("sim_noack1", 8'(SHDN_ACK), 8'h0);
    to_edge(80); chk("sim_noack2", 8'({SHDN_ACK, FAULT}), 8'h1); SHDN_REQ = 0; PG = 1;
    to_edge(86); chk("r4_en0", 8'({EN, FAULT}), 8'h2);
    to_edge(92); chk("r4_on", 8'({EN, READY}), 8'hF);
    to_edge(93); SHDN_REQ = 1;
    to_edge(94); chk("r4_dn", 8'({EN, READY}), 8'hE);
    to_edge(96); chk("r4_en2", 8'(EN), 8'h3); RN = 0; SHDN_REQ = 0;
    to_edge(97); chk("mid_rst", 8'({EN, RSTN_OUT, READY, SHDN_ACK, FAULT}), 8'h0);
    to_edge(98); RN = 1;
    to_edge(103); chk("r5_pre", 8'(EN), 8'h0);
    to_edge(104); chk("r5_en0", 8'(EN), 8'h1);
    to_edge(106); chk("r5_en1", 8'(EN), 8'h3);
    to_edge(108); chk("r5_en2", 8'(EN), 8'h7);
    to_edge(109); chk("r5_ready_pre", 8'(READY), 8'h0);
    to_edge(110); chk("r5_ready", 8'({RSTN_OUT, READY, FAULT}), 8'h6);
    to_edge(112);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
